// File: rtl/uart_rx_deserializer.sv
// Purpose: 8N1 UART receiver; deserializes rx_i into bytes with framing/overrun flags.
// Latency: start edge to rx_valid_o = SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+/-1).
// Backpressure: one-byte holding register; a byte arriving while it is full and not drained is dropped (overrun_o).
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] HALF_RELOAD = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [BW-1:0]          r_baud_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   r_busy;

  logic                   w_rx_s;
  logic                   w_baud_zero;
  logic                   w_pop;
  state_t                 w_state_nxt;
  logic [BW-1:0]          w_baud_nxt;
  logic [2:0]             w_bit_nxt;
  logic [7:0]             w_shift_nxt;
  logic                   w_load;
  logic                   w_ferr;
  logic                   w_ovr;

  assign w_rx_s      = r_sync[SYNC_STAGES-1];
  assign w_baud_zero = (r_baud_cnt == '0);
  assign w_pop       = r_valid & rx_ready_i;

  // Metastability synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
    end
  end

  // Next-state, counter and event decode for the receive FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    w_ovr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_baud_nxt  = HALF_RELOAD;
        end
      end
      S_START: begin
        if (w_baud_zero) begin
          if (w_rx_s) begin
            // Line went back high by mid start bit: treat as a glitch.
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = 3'd0;
            w_baud_nxt  = FULL_RELOAD;
          end
        end else begin
          w_baud_nxt = r_baud_cnt - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (w_baud_zero) begin
          // LSB arrives first, so shift in from the top.
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_baud_nxt  = FULL_RELOAD;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt - BAUD_ONE;
        end
      end
      S_STOP: begin
        if (w_baud_zero) begin
          if (w_rx_s) begin
            w_state_nxt = S_IDLE;
            // A byte drained on this same edge frees the holding register.
            if (!r_valid || w_pop) begin
              w_load = 1'b1;
            end else begin
              w_ovr = 1'b1;
            end
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_baud_nxt = r_baud_cnt - BAUD_ONE;
        end
      end
      S_WAIT_HIGH: begin
        // Do not re-arm on a held-low (break) line.
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, counters and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Holding register and valid/ready handshake; a load wins over a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Single-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
    end
  end

  assign rx_data_o   = r_data;
  assign rx_valid_o  = r_valid;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed scenarios plus randomized frames.
// Expected bytes and error events come from a frame-level model of the holding register.
// A monitor pops the expected-byte queue on each accepted handshake.
module tb_uart_rx_deserializer;

  localparam int CPB      = 16;
  localparam int SYNC     = 2;
  localparam int STOP_IDX = SYNC + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         exp_ovr  = 0;
  int         obs_ferr = 0;
  int         obs_ovr  = 0;
  bit         m_full   = 1'b0;
  logic [7:0] m_data   = 8'h00;

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (rx_i),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every accepted byte and count error pulses.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid_o && rx_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data_o);
        end else begin
          check("byte", 32'(rx_data_o), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err_o) obs_ferr++;
      if (overrun_o) obs_ovr++;
      if (frame_err_o || overrun_o)
        check("err_exclusive", 32'(frame_err_o & overrun_o), 32'(0));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: what one complete frame does to the holding register.
  function automatic void model_frame(input logic [7:0] d, input bit stop_ok,
                                      input bit rdy_pulse, input bit rdy_held);
    if (!stop_ok) begin
      exp_ferr++;
    end else if (!m_full || rdy_pulse || rdy_held) begin
      exp_q.push_back(d);
      m_data = d;
      m_full = !rdy_held;
    end else begin
      exp_ovr++;
    end
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit rdy_pulse,
                            input bit rdy_held, input int extra_low);
    model_frame(d, stop_ok, rdy_pulse, rdy_held);
    rx_ready_i = rdy_held;
    for (int c = 0; c < 10 * CPB; c++) begin
      int slot;
      slot = c / CPB;
      if (slot == 0) rx_i = 1'b0;
      else if (slot <= 8) rx_i = d[slot-1];
      else rx_i = stop_ok;
      if (rdy_pulse) rx_ready_i = (c == STOP_IDX);
      tick(1);
    end
    if (!stop_ok) begin
      rx_i = 1'b0;
      tick(extra_low);
    end
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;
    tick(4);
    check("valid_after_frame", 32'(rx_valid_o), 32'(m_full));
    if (m_full) check("data_after_frame", 32'(rx_data_o), 32'(m_data));
  endtask

  task automatic drain();
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    m_full     = 1'b0;
    check("valid_after_drain", 32'(rx_valid_o), 32'(0));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_ferr_count"}, 32'(obs_ferr), 32'(exp_ferr));
    check({tag, "_ovr_count"}, 32'(obs_ovr), 32'(exp_ovr));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(rx_data_o), 32'(0));
    check({tag, "_valid"}, 32'(rx_valid_o), 32'(0));
    check({tag, "_ferr"}, 32'(frame_err_o), 32'(0));
    check({tag, "_ovr"}, 32'(overrun_o), 32'(0));
    check({tag, "_busy"}, 32'(busy_o), 32'(0));
  endtask

  initial begin
    bit saw_busy;
    rst_n      = 1'b0;
    rx_i       = 1'b1;
    rx_ready_i = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(5);

    // 1: byte held until ready, then cleared the next cycle.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
    tick(10);
    check("t1_still_valid", 32'(rx_valid_o), 32'(1));
    check("t1_still_data", 32'(rx_data_o), 32'(8'hA5));
    drain();
    check_counts("t1");

    // 2: short low glitch is rejected.
    rx_i     = 1'b0;
    saw_busy = 1'b0;
    tick(4);
    rx_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (busy_o) saw_busy = 1'b1;
      tick(1);
    end
    check("t2_busy_seen", 32'(saw_busy), 32'(1));
    check("t2_busy_low", 32'(busy_o), 32'(0));
    check("t2_no_valid", 32'(rx_valid_o), 32'(0));
    check_counts("t2");

    // 3: framing error with long low line, then recovery.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 48);
    check_counts("t3a");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
    drain();
    check_counts("t3b");

    // 4: overrun keeps the first byte.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
    check_counts("t4");
    drain();

    // 5: drain on the very stop-sample edge avoids overrun.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, 0);
    check_counts("t5");
    drain();

    // 6: reset in the middle of bit 4 with a byte already held.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
    for (int c = 0; c < 10 * CPB; c++) begin
      rx_i = (c < CPB) ? 1'b0 : 1'b1;
      if (c == 5 * CPB + 8) begin
        check("t6_busy_before_reset", 32'(busy_o), 32'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        break;
      end
      tick(1);
    end
    exp_q.delete();
    m_full = 1'b0;
    rx_i   = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, 0);
    drain();
    check_counts("t6");

    // Randomized frames: random data, stop bit, and ready mode.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      bit         ok;
      bit         held;
      d    = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      held = 1'($urandom_range(0, 1));
      send_frame(d, ok, 1'b0, held, ok ? 0 : int'($urandom_range(0, 30)));
      if (m_full) drain();
      tick(int'($urandom_range(1, 20)));
    end
    check_counts("rand");
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
